// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions used by the IF block and pc_hazard_ctrl.
//   ctrl_state_e  : fetch-sequencer states (hold after reset, run, waiting on IMEM)
//   REG_ZERO      : architectural zero register index (never a real dependency)
//   PC_SRC_SEQ/BR : PCSource encodings (PC+4 / ID branch target)
//   sat_inc_wait  : saturating increment for the 4-bit IMEM wait counter
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        StHold     = 2'd0,
        StRun      = 2'd1,
        StImemWait = 2'd2
    } ctrl_state_e;

    localparam int unsigned REG_ZERO   = 0;
    localparam logic        PC_SRC_SEQ = 1'b0;
    localparam logic        PC_SRC_BR  = 1'b1;

    localparam int unsigned WAIT_CNT_W = 4;

    function automatic logic [WAIT_CNT_W-1:0] sat_inc_wait(input logic [WAIT_CNT_W-1:0] cnt);
        return (cnt == '1) ? cnt : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare, shared with the forwarding unit.
// A load in EX whose destination is a non-zero register read by the instruction in ID
// forces a one-cycle stall.
//   ex_mem_read_i : EX instruction is a load
//   ex_rt_i       : load destination register
//   id_rs_i/_rt_i : source registers of the ID instruction
//   load_use_o    : hazard present this cycle
module load_use_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic              ex_mem_read_i,
    input  logic [REG_AW-1:0] ex_rt_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    output logic              load_use_o
);

    always_comb begin
        load_use_o = ex_mem_read_i
                   && (ex_rt_i != REG_AW'(REG_ZERO))
                   && ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));
    end

endmodule

// File: rtl/pc_hazard_ctrl.sv
// IF-stage sequencer: drives PC update/source, IF/ID write/flush and the ID/EX bubble.
// Priority while fetching: load-use stall > taken branch > IMEM wait > normal fetch.
// One HOLD cycle follows reset. ImemTimeout is sticky until Reset.
// Optional feature: define PERF_CNT_EN to build saturating StallCycles/FlushCount counters;
// otherwise both ports are tied to zero.
// Ports:
//   Clk, Reset                 clock (rising edge), asynchronous active-high reset
//   ID_Rs, ID_Rt               ID source registers
//   EX_MemRead, EX_Rt          EX load flag and destination
//   ID_Branch, ID_BrTaken      branch in ID and its resolved condition
//   IMemReady                  instruction memory data valid
//   PCWrite, PCSource          PC enable and select
//   IFIDWrite, IFFlush         IF/ID enable and NOP insert
//   CtrlBubble                 zero ID/EX control
//   ImemTimeout                sticky IMEM timeout
//   StallCycles, FlushCount    performance counters
module pc_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [REG_AW-1:0] ID_Rs,
    input  logic [REG_AW-1:0] ID_Rt,
    input  logic              EX_MemRead,
    input  logic [REG_AW-1:0] EX_Rt,
    input  logic              ID_Branch,
    input  logic              ID_BrTaken,
    input  logic              IMemReady,
    output logic              PCWrite,
    output logic              PCSource,
    output logic              IFIDWrite,
    output logic              IFFlush,
    output logic              CtrlBubble,
    output logic              ImemTimeout,
    output logic [CNT_W-1:0]  StallCycles,
    output logic [CNT_W-1:0]  FlushCount
);

    localparam logic [WAIT_CNT_W-1:0] WaitLimit = WAIT_CNT_W'(MAX_WAIT);

    ctrl_state_e           state_q, state_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic                  timeout_q, timeout_d;
    logic                  load_use;
    logic                  stall_evt;
    logic                  flush_evt;

    load_use_detect #(
        .REG_AW (REG_AW)
    ) u_load_use_detect (
        .ex_mem_read_i (EX_MemRead),
        .ex_rt_i       (EX_Rt),
        .id_rs_i       (ID_Rs),
        .id_rt_i       (ID_Rt),
        .load_use_o    (load_use)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= StHold;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        PCWrite    = 1'b0;
        PCSource   = PC_SRC_SEQ;
        IFIDWrite  = 1'b1;
        IFFlush    = 1'b0;
        CtrlBubble = 1'b0;
        stall_evt  = 1'b0;
        flush_evt  = 1'b0;

        unique case (state_q)
            StHold: begin
                IFFlush    = 1'b1;
                CtrlBubble = 1'b1;
                state_d    = StRun;
            end
            StRun, StImemWait: begin
                if (load_use) begin
                    // Freeze PC and IF/ID; a pending branch is re-evaluated next cycle.
                    IFIDWrite  = 1'b0;
                    CtrlBubble = 1'b1;
                    stall_evt  = 1'b1;
                end else if (ID_Branch && ID_BrTaken) begin
                    // Redirect wins over an outstanding fetch, which is simply dropped.
                    PCWrite    = 1'b1;
                    PCSource   = PC_SRC_BR;
                    IFFlush    = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = StRun;
                    flush_evt  = 1'b1;
                end else if (!IMemReady) begin
                    IFFlush    = 1'b1;
                    state_d    = StImemWait;
                    wait_cnt_d = sat_inc_wait(wait_cnt_q);
                    stall_evt  = 1'b1;
                    if (wait_cnt_d == WaitLimit) begin
                        timeout_d = 1'b1;
                    end
                end else begin
                    PCWrite    = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = StRun;
                end
            end
            default: state_d = StHold;
        endcase
    end

    assign ImemTimeout = timeout_q;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_evt && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (flush_evt && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign StallCycles = stall_cnt_q;
    assign FlushCount  = flush_cnt_q;
`else
    logic unused_evt;
    assign unused_evt  = stall_evt ^ flush_evt;
    assign StallCycles = '0;
    assign FlushCount  = '0;
`endif

endmodule

// File: tb/tb_pc_hazard_ctrl.sv
// Self-checking bench for pc_hazard_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a rule-level behavioural model.
module tb_pc_hazard_ctrl;

    localparam int unsigned REG_AW   = 5;
    localparam int unsigned MAX_WAIT = 4;
    localparam int unsigned CNT_W    = 16;
    localparam longint      CNT_MAX  = (longint'(1) << CNT_W) - 1;

    logic              Clk = 1'b0;
    logic              Reset = 1'b1;
    logic [REG_AW-1:0] ID_Rs = '0;
    logic [REG_AW-1:0] ID_Rt = '0;
    logic              EX_MemRead = 1'b0;
    logic [REG_AW-1:0] EX_Rt = '0;
    logic              ID_Branch = 1'b0;
    logic              ID_BrTaken = 1'b0;
    logic              IMemReady = 1'b1;
    logic              PCWrite;
    logic              PCSource;
    logic              IFIDWrite;
    logic              IFFlush;
    logic              CtrlBubble;
    logic              ImemTimeout;
    logic [CNT_W-1:0]  StallCycles;
    logic [CNT_W-1:0]  FlushCount;

    pc_hazard_ctrl #(
        .REG_AW   (REG_AW),
        .MAX_WAIT (MAX_WAIT),
        .CNT_W    (CNT_W)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .ID_Rs       (ID_Rs),
        .ID_Rt       (ID_Rt),
        .EX_MemRead  (EX_MemRead),
        .EX_Rt       (EX_Rt),
        .ID_Branch   (ID_Branch),
        .ID_BrTaken  (ID_BrTaken),
        .IMemReady   (IMemReady),
        .PCWrite     (PCWrite),
        .PCSource    (PCSource),
        .IFIDWrite   (IFIDWrite),
        .IFFlush     (IFFlush),
        .CtrlBubble  (CtrlBubble),
        .ImemTimeout (ImemTimeout),
        .StallCycles (StallCycles),
        .FlushCount  (FlushCount)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: only "first cycle after reset", wait run length, sticky timeout
    // and event totals are tracked; outputs follow from the priority rules directly.
    bit     m_hold = 1'b1;
    bit     m_tmo = 1'b0;
    int     m_wait = 0;
    longint m_stalls = 0;
    longint m_flushes = 0;
    bit     n_hold;
    bit     n_tmo;
    int     n_wait;
    longint n_stalls;
    longint n_flushes;

    always @(negedge Clk) begin
        bit e_pcw, e_src, e_ifidw, e_flush, e_bub, lu, br;
        longint e_stalls, e_flushes;
        bit e_tmo;
        n_hold = 1'b0; n_tmo = m_tmo; n_wait = m_wait;
        n_stalls = m_stalls; n_flushes = m_flushes;
        e_tmo = Reset ? 1'b0 : m_tmo;
        e_stalls = Reset ? 0 : m_stalls;
        e_flushes = Reset ? 0 : m_flushes;
        lu = EX_MemRead && (EX_Rt != 0) && ((EX_Rt == ID_Rs) || (EX_Rt == ID_Rt));
        br = ID_Branch && ID_BrTaken;
        if (Reset || m_hold) begin
            {e_pcw, e_src, e_ifidw, e_flush, e_bub} = 5'b00111;
            if (Reset) begin
                n_hold = 1'b1; n_tmo = 1'b0; n_wait = 0; n_stalls = 0; n_flushes = 0;
            end
        end else if (lu) begin
            {e_pcw, e_src, e_ifidw, e_flush, e_bub} = 5'b00001;
        end else if (br) begin
            {e_pcw, e_src, e_ifidw, e_flush, e_bub} = 5'b11110;
            n_wait = 0;
            n_flushes = (m_flushes < CNT_MAX) ? m_flushes + 1 : m_flushes;
        end else if (!IMemReady) begin
            {e_pcw, e_src, e_ifidw, e_flush, e_bub} = 5'b00110;
            n_wait = (m_wait < 15) ? m_wait + 1 : 15;
            if (n_wait == int'(MAX_WAIT)) n_tmo = 1'b1;
        end else begin
            {e_pcw, e_src, e_ifidw, e_flush, e_bub} = 5'b10100;
            n_wait = 0;
        end
        if (!Reset && !m_hold && !e_pcw) begin
            n_stalls = (m_stalls < CNT_MAX) ? m_stalls + 1 : m_stalls;
        end
`ifndef PERF_CNT_EN
        e_stalls = 0;
        e_flushes = 0;
`endif
        check("PCWrite", PCWrite, e_pcw);
        if (e_pcw || Reset || m_hold) check("PCSource", PCSource, e_src);
        check("IFIDWrite", IFIDWrite, e_ifidw);
        check("IFFlush", IFFlush, e_flush);
        check("CtrlBubble", CtrlBubble, e_bub);
        check("ImemTimeout", ImemTimeout, e_tmo);
        check("StallCycles", StallCycles, e_stalls);
        check("FlushCount", FlushCount, e_flushes);
    end

    always @(posedge Clk) begin
        m_hold <= n_hold; m_tmo <= n_tmo; m_wait <= n_wait;
        m_stalls <= n_stalls; m_flushes <= n_flushes;
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        EX_MemRead = 1'b0; ID_Branch = 1'b0; ID_BrTaken = 1'b0; IMemReady = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        longint exp_st, exp_fl;
        // Reset for two edges, then exactly one HOLD cycle.
        Reset = 1'b1; idle();
        step(); step();
        Reset = 1'b0;
        #2;
        check("hold_pcwrite", PCWrite, 0);
        check("hold_ifflush", IFFlush, 1);
        check("hold_bubble", CtrlBubble, 1);
        step(); #2;
        check("run_pcwrite", PCWrite, 1);
        check("run_pcsource", PCSource, 0);
        check("run_ifflush", IFFlush, 0);

        // Single load-use cycle on Rs.
        step();
        EX_MemRead = 1'b1; EX_Rt = 5'd8; ID_Rs = 5'd8; ID_Rt = 5'd3;
        #2;
        check("lu_pcwrite", PCWrite, 0);
        check("lu_ifidwrite", IFIDWrite, 0);
        check("lu_bubble", CtrlBubble, 1);
        step(); idle(); #2;
        check("lu_after_pcwrite", PCWrite, 1);
        check("lu_after_bubble", CtrlBubble, 0);

        // Load to register zero is never a hazard.
        step();
        EX_MemRead = 1'b1; EX_Rt = 5'd0; ID_Rs = 5'd0; ID_Rt = 5'd0;
        #2;
        check("r0_pcwrite", PCWrite, 1);
        check("r0_ifidwrite", IFIDWrite, 1);

        // Load-use beats a taken branch; branch goes the next cycle.
        step();
        EX_MemRead = 1'b1; EX_Rt = 5'd5; ID_Rs = 5'd1; ID_Rt = 5'd5;
        ID_Branch = 1'b1; ID_BrTaken = 1'b1;
        #2;
        check("lubr_pcwrite", PCWrite, 0);
        check("lubr_ifidwrite", IFIDWrite, 0);
        check("lubr_ifflush", IFFlush, 0);
        step(); EX_MemRead = 1'b0; #2;
        check("br_pcwrite", PCWrite, 1);
        check("br_pcsource", PCSource, 1);
        check("br_ifflush", IFFlush, 1);
        step(); idle();

        // MAX_WAIT wait cycles raise the sticky timeout at the last edge.
        IMemReady = 1'b0;
        for (int i = 0; i < int'(MAX_WAIT); i++) begin
            #2;
            check("wait_pcwrite", PCWrite, 0);
            check("wait_no_tmo_yet", ImemTimeout, 0);
            step();
        end
        IMemReady = 1'b1; #2;
        check("tmo_set", ImemTimeout, 1);
        check("tmo_ready_pcwrite", PCWrite, 1);
        step(); step(); #2;
        check("tmo_sticky", ImemTimeout, 1);

        // Reset in the middle of a wait acts at once.
        IMemReady = 1'b0;
        step(); step();
        Reset = 1'b1; #1;
        check("async_rst_tmo", ImemTimeout, 0);
        check("async_rst_pcwrite", PCWrite, 0);
        check("async_rst_ifflush", IFFlush, 1);
        check("async_rst_bubble", CtrlBubble, 1);
        step(); step();
        Reset = 1'b0; idle();

        // Counters: three stall cycles and two taken branches after the HOLD cycle.
        step();
        EX_MemRead = 1'b1; EX_Rt = 5'd7; ID_Rs = 5'd7;
        step(); step(); step();
        EX_MemRead = 1'b0; ID_Branch = 1'b1; ID_BrTaken = 1'b1;
        step(); step();
        idle(); #2;
`ifdef PERF_CNT_EN
        exp_st = 3; exp_fl = 2;
`else
        exp_st = 0; exp_fl = 0;
`endif
        check("perf_stalls", StallCycles, exp_st);
        check("perf_flushes", FlushCount, exp_fl);

        // Randomized traffic; the per-cycle model compare does the checking.
        for (int c = 0; c < 3000; c++) begin
            step();
            Reset      = ($urandom_range(0, 249) == 0);
            EX_MemRead = ($urandom_range(0, 2) == 0);
            EX_Rt      = REG_AW'($urandom_range(0, 3));
            ID_Rs      = REG_AW'($urandom_range(0, 3));
            ID_Rt      = REG_AW'($urandom_range(0, 3));
            ID_Branch  = ($urandom_range(0, 3) == 0);
            ID_BrTaken = $urandom_range(0, 1) == 1;
            IMemReady  = (c % 200 < 20) ? ($urandom_range(0, 7) == 0)
                                        : ($urandom_range(0, 3) != 0);
        end
        step(); Reset = 1'b0; idle();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
